lagged_correlator_core: RTL and testbench
=========================================

Name: lagged_correlator_core

Overview:
- Parametrised multi-lag correlation engine for the interferometer correlator; the next generation of the fixed zero-lag, fixed-14-input core.
- Counts coincidences for every input pair (i<j) at lags 0..NUM_LAGS-1 over an integration period.
- At each period boundary it snapshots all counters and streams them over a valid/ready interface toward the UART framer.
- Sits between the pulse input pins and the TX serialiser; sample and integration strobes come from the existing strobe generators.

Parameters:
- NUM_INPUTS, 14, number of 1-bit pulse channels (>=2)
- NUM_LAGS, 2, lags per pair, 0..NUM_LAGS-1 (>=1)
- RESOLUTION, 16, accumulator and output word width
- SATURATE, 1, 1 = counters clamp at all-ones; 0 = counters wrap modulo 2^RESOLUTION
- INVERT_INPUTS, 1, 1 = pulse_in is active-low and inverted after synchronisation

Ports:
- clki  in  1  system clock; the only clock
- rst_n  in  1  asynchronous active-low reset
- pulse_in  in  NUM_INPUTS  asynchronous pulse channels
- sample_stb  in  1  one-cycle sample strobe
- integ_stb  in  1  one-cycle end-of-integration strobe
- out_data  out  RESOLUTION  correlation count
- out_pair  out  clog2(NUM_CORR)  pair index of the current word
- out_lag  out  clog2(NUM_LAGS)+1  lag of the current word
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accept
- out_last  out  1  marks the final word of a frame
- busy  out  1  high while streaming
- overrun  out  1  one-cycle pulse when integ_stb is dropped

Behaviour:
- Derived constant: NUM_CORR = NUM_INPUTS*(NUM_INPUTS-1)/2.
- Input path: 2-FF synchroniser per channel, then optional inversion. Synchronised value x is used by sample_stb two cycles after a pin change.
- History: per-channel shift register h[1..NUM_LAGS-1]. It shifts only on sample_stb (h[1] <= x). Reset value is 0.
- Accumulation, on sample_stb: for pair p=(i,j) and lag k, acc[p][k] increments when x_i & h_j[k] (h_j[0] = x_j).
  - SATURATE=1: all-ones holds.
  - SATURATE=0: wraps to 0.
- Pair ordering: p enumerates (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1).
- States: IDLE and STREAM.
  - In IDLE, integ_stb sets snap[p][k] <= acc + this-cycle increment, clears all acc to 0, resets the word index w to 0, and moves to STREAM. out_valid rises the following cycle.
  - A sample_stb in the same cycle as integ_stb is counted into the closing snapshot; the new period starts from zero.
- STREAM: word w = p*NUM_LAGS + k.
  - out_data = snap[p][k], with out_pair and out_lag set to match.
  - Outputs are held stable while out_valid & !out_ready.
  - On handshake, w increments.
  - out_last = 1 when w = NUM_CORR*NUM_LAGS-1. The handshake on that word returns the FSM to IDLE with out_valid=0 the next cycle.
  - Maximum throughput is one word per cycle.
- busy = (state == STREAM).
- integ_stb while in STREAM: the snapshot is not taken, acc is not cleared and keeps accumulating (the period extends), and overrun pulses high for 1 cycle.
- Accumulation continues during STREAM regardless of backpressure.
- Reset (async, any time, including mid-stream): state IDLE, all acc/snap/history/synchronisers cleared to 0. Outputs out_valid=0, out_last=0, busy=0, overrun=0, out_data=0, out_pair=0, out_lag=0. Any frame in flight is abandoned with no partial words afterwards.
- Widths: the increment is a single bit. The saturation compare is on the RESOLUTION-bit value; no wider intermediate is exposed.

Decomposition:
- Package correlator_pkg:
  - NUM_CORR function
  - clog2 helper
  - pair_i(p) / pair_j(p) index functions
  - state enum {IDLE, STREAM}
- Sub-module corr_accumulator: one RESOLUTION-bit counter with inc, clear, snapshot register and SATURATE behaviour. Instantiated NUM_CORR*NUM_LAGS times via generate.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> all outputs 0 in the same cycle; after release out_valid stays 0 until the next integ_stb.
- Zero-lag count: N=3, NUM_LAGS=2, ch0=ch1=1 and ch2=0 for 5 strobes, then integ_stb -> 6 words in order (0,1)L0=5, (0,1)L1=4, others 0; out_last on word 6.
- Lag detection: ch1 pulse at sample 2, ch0 pulse at sample 3 -> (0,1)L0=0, (0,1)L1=1, all others 0.
- Saturation vs wrap: RESOLUTION=4, 20 coincident samples -> SATURATE=1 gives 15; SATURATE=0 gives 4.
- Backpressure and overrun: out_ready=0 for 10 cycles -> word 0 held stable. integ_stb during STREAM -> 1-cycle overrun; the next frame contains counts from both periods.
- Coincident strobes: sample_stb and integ_stb in the same cycle with ch0=ch1=1 -> that sample appears in the snapshot; the next frame excludes it (count 0 if no further samples).

Source files
------------

// File: rtl/correlator_pkg.sv
// Shared types and elaboration-time helpers for the lagged correlator.
package correlator_pkg;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  function automatic int num_corr(input int n);
    return n * (n - 1) / 2;
  endfunction

  // Never returns less than 1 so that single-entry fields still get a bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int pair_i(input int p, input int n);
    int idx;
    int res;
    idx = 0;
    res = 0;
    for (int i = 0; i < n - 1; i++)
      for (int j = i + 1; j < n; j++) begin
        if (idx == p) res = i;
        idx++;
      end
    return res;
  endfunction

  function automatic int pair_j(input int p, input int n);
    int idx;
    int res;
    idx = 0;
    res = 0;
    for (int i = 0; i < n - 1; i++)
      for (int j = i + 1; j < n; j++) begin
        if (idx == p) res = j;
        idx++;
      end
    return res;
  endfunction

endpackage

// File: rtl/corr_accumulator.sv
// One coincidence counter with clear, snapshot register and clamp/wrap overflow.
module corr_accumulator #(
  parameter int RESOLUTION = 16,
  parameter int SATURATE   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_inc,
  input  logic                  i_clear,
  input  logic                  i_snap,
  output logic [RESOLUTION-1:0] o_snap
);

  logic [RESOLUTION-1:0] r_acc;
  logic [RESOLUTION-1:0] r_snap;
  logic [RESOLUTION-1:0] w_next;

  always_comb begin
    w_next = r_acc + RESOLUTION'(i_inc);
    if ((SATURATE != 0) && (&r_acc)) w_next = r_acc;
  end

  // The snapshot includes this cycle's increment; the cleared counter does not.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc  <= '0;
      r_snap <= '0;
    end else begin
      r_acc <= i_clear ? '0 : w_next;
      if (i_snap) r_snap <= w_next;
    end
  end

  assign o_snap = r_snap;

endmodule

// File: rtl/lagged_correlator_core.sv
// Multi-lag pairwise coincidence counter; snapshots every pair/lag at each
// integration boundary and streams the snapshot over valid/ready.
module lagged_correlator_core
  import correlator_pkg::*;
#(
  parameter int NUM_INPUTS    = 14,
  parameter int NUM_LAGS      = 2,
  parameter int RESOLUTION    = 16,
  parameter int SATURATE      = 1,
  parameter int INVERT_INPUTS = 1,
  localparam int NUM_CORR     = num_corr(NUM_INPUTS),
  localparam int PAIR_W       = clog2(NUM_CORR),
  localparam int LAG_W        = clog2(NUM_LAGS) + 1
) (
  input  logic                  clki,
  input  logic                  rst_n,
  input  logic [NUM_INPUTS-1:0] pulse_in,
  input  logic                  sample_stb,
  input  logic                  integ_stb,
  output logic [RESOLUTION-1:0] out_data,
  output logic [PAIR_W-1:0]     out_pair,
  output logic [LAG_W-1:0]      out_lag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  overrun
);

  localparam int NUM_WORDS = NUM_CORR * NUM_LAGS;
  localparam int W_W       = clog2(NUM_WORDS);
  localparam int HIST_N    = (NUM_LAGS > 1) ? NUM_LAGS - 1 : 1;

  state_t                  r_state, w_state_nxt;
  logic [NUM_INPUTS-1:0]   r_sync1, r_sync2, w_x;
  // Channel 0 is only ever the leading element of a pair, so it needs no history.
  logic [NUM_INPUTS-1:1]   r_hist [1:HIST_N];
  logic [RESOLUTION-1:0]   w_snap [NUM_WORDS];
  logic [W_W-1:0]          r_w;
  logic [PAIR_W-1:0]       r_pair;
  logic [LAG_W-1:0]        r_lag;
  logic                    r_overrun, w_take, w_hs, w_last, w_busy;

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= pulse_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_x = (INVERT_INPUTS != 0) ? ~r_sync2 : r_sync2;

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= HIST_N; k++) r_hist[k] <= '0;
    end else if (sample_stb) begin
      r_hist[1] <= w_x[NUM_INPUTS-1:1];
      for (int k = 2; k <= HIST_N; k++) r_hist[k] <= r_hist[k-1];
    end
  end

  for (genvar p = 0; p < NUM_CORR; p++) begin : g_pair
    localparam int PI = pair_i(p, NUM_INPUTS);
    localparam int PJ = pair_j(p, NUM_INPUTS);
    for (genvar k = 0; k < NUM_LAGS; k++) begin : g_lag
      logic w_inc;
      if (k == 0) begin : g_l0
        assign w_inc = sample_stb & w_x[PI] & w_x[PJ];
      end else begin : g_lk
        assign w_inc = sample_stb & w_x[PI] & r_hist[k][PJ];
      end
      corr_accumulator #(
        .RESOLUTION(RESOLUTION),
        .SATURATE  (SATURATE)
      ) u_acc (
        .i_clk  (clki),
        .i_rst_n(rst_n),
        .i_inc  (w_inc),
        .i_clear(w_take),
        .i_snap (w_take),
        .o_snap (w_snap[p*NUM_LAGS+k])
      );
    end
  end

  assign w_busy = (r_state == STREAM);
  assign w_last = w_busy && (r_w == W_W'(NUM_WORDS - 1));
  assign w_hs   = w_busy && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    case (r_state)
      IDLE: begin
        if (integ_stb) begin
          w_take      = 1'b1;
          w_state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (out_ready && w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Word index and its pair/lag decomposition advance together, avoiding a divider.
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      r_w       <= '0;
      r_pair    <= '0;
      r_lag     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_busy && integ_stb;
      if (w_take || (w_hs && w_last)) begin
        r_w    <= '0;
        r_pair <= '0;
        r_lag  <= '0;
      end else if (w_hs) begin
        r_w <= r_w + W_W'(1);
        if (r_lag == LAG_W'(NUM_LAGS - 1)) begin
          r_lag  <= '0;
          r_pair <= r_pair + PAIR_W'(1);
        end else begin
          r_lag <= r_lag + LAG_W'(1);
        end
      end
    end
  end

  assign out_data  = w_busy ? w_snap[r_w] : '0;
  assign out_pair  = r_pair;
  assign out_lag   = r_lag;
  assign out_valid = w_busy;
  assign out_last  = w_last;
  assign busy      = w_busy;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_lagged_correlator_core.sv
// Bench for lagged_correlator_core: a saturating and a wrapping instance share
// all inputs and are checked against a pair/lag coincidence model.
module tb_lagged_correlator_core;

  localparam int NI  = 3;
  localparam int NL  = 2;
  localparam int RES = 4;
  localparam int NW  = 6;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [NI-1:0]   pulse_in = '1;
  logic            sample_stb = 1'b0, integ_stb = 1'b0, out_ready = 1'b0;
  logic [RES-1:0]  data_a, data_b;
  logic [1:0]      pair_a, pair_b, lag_a, lag_b;
  logic            valid_a, valid_b, last_a, last_b, busy_a, busy_b, ovr_a, ovr_b;

  lagged_correlator_core #(.NUM_INPUTS(NI), .NUM_LAGS(NL), .RESOLUTION(RES),
                           .SATURATE(1), .INVERT_INPUTS(1)) u_sat (
    .clki(clk), .rst_n(rst_n), .pulse_in(pulse_in), .sample_stb(sample_stb),
    .integ_stb(integ_stb), .out_data(data_a), .out_pair(pair_a), .out_lag(lag_a),
    .out_valid(valid_a), .out_ready(out_ready), .out_last(last_a), .busy(busy_a),
    .overrun(ovr_a));

  lagged_correlator_core #(.NUM_INPUTS(NI), .NUM_LAGS(NL), .RESOLUTION(RES),
                           .SATURATE(0), .INVERT_INPUTS(1)) u_wrap (
    .clki(clk), .rst_n(rst_n), .pulse_in(pulse_in), .sample_stb(sample_stb),
    .integ_stb(integ_stb), .out_data(data_b), .out_pair(pair_b), .out_lag(lag_b),
    .out_valid(valid_b), .out_ready(out_ready), .out_last(last_b), .busy(busy_b),
    .overrun(ovr_b));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: raw per-word counts, last NL samples, expected snapshot.
  int            cnt [NW];
  int            exp_sat [NW];
  int            exp_wrap [NW];
  int            got_a [NW];
  int            got_b [NW];
  int            word_i [NW], word_j [NW], word_pair [NW], word_lag [NW];
  logic [NI-1:0] past [$];
  bit            m_busy = 1'b0;

  typedef struct {
    int stall;
    int pair;
    int lag;
    int data;
    bit last;
  } word_t;
  word_t zl_tab [NW];

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic void build_map();
    int w;
    int p;
    w = 0;
    p = 0;
    for (int i = 0; i < NI; i++)
      for (int j = i + 1; j < NI; j++) begin
        for (int k = 0; k < NL; k++) begin
          word_i[w] = i; word_j[w] = j; word_pair[w] = p; word_lag[w] = k;
          w++;
        end
        p++;
      end
  endfunction

  function automatic void model_reset();
    for (int w = 0; w < NW; w++) cnt[w] = 0;
    past.delete();
    m_busy = 1'b0;
  endfunction

  function automatic void model_sample(input logic [NI-1:0] x);
    for (int w = 0; w < NW; w++) begin
      logic [NI-1:0] tap;
      if (word_lag[w] == 0) tap = x;
      else if (past.size() >= word_lag[w]) tap = past[word_lag[w]-1];
      else tap = '0;
      if (x[word_i[w]] && tap[word_j[w]]) cnt[w]++;
    end
    past.push_front(x);
    if (past.size() > NL) void'(past.pop_back());
  endfunction

  function automatic void model_integ();
    if (!m_busy) begin
      for (int w = 0; w < NW; w++) begin
        exp_sat[w]  = (cnt[w] > 15) ? 15 : cnt[w];
        exp_wrap[w] = cnt[w] % 16;
        cnt[w] = 0;
      end
      m_busy = 1'b1;
    end
  endfunction

  // All tasks start and end on a falling edge.
  task automatic strobe(input logic [NI-1:0] x, input bit with_integ);
    @(negedge clk);
    pulse_in = ~x;
    @(negedge clk);
    @(negedge clk);
    sample_stb = 1'b1;
    integ_stb  = with_integ;
    @(negedge clk);
    sample_stb = 1'b0;
    integ_stb  = 1'b0;
    model_sample(x);
    if (with_integ) model_integ();
  endtask

  task automatic integ();
    bit was_busy;
    was_busy = m_busy;
    integ_stb = 1'b1;
    @(negedge clk);
    integ_stb = 1'b0;
    model_integ();
    if (!was_busy) begin
      check("valid_after_integ", valid_a, 1);
      check("no_overrun_idle", ovr_a, 0);
    end else begin
      check("overrun_pulse_sat", ovr_a, 1);
      check("overrun_pulse_wrap", ovr_b, 1);
      @(negedge clk);
      check("overrun_one_cycle", ovr_a, 0);
    end
  endtask

  task automatic read_frame(input int ready_pct);
    int w;
    int guard;
    bit rdy;
    w = 0;
    guard = 0;
    while (w < NW && guard < 300) begin
      rdy = ($urandom_range(99) < ready_pct);
      out_ready = rdy;
      if (valid_a && rdy) begin
        got_a[w] = data_a;
        got_b[w] = data_b;
        check($sformatf("data_sat_w%0d", w), data_a, exp_sat[w]);
        check($sformatf("data_wrap_w%0d", w), data_b, exp_wrap[w]);
        check($sformatf("pair_w%0d", w), pair_a, word_pair[w]);
        check($sformatf("lag_w%0d", w), lag_a, word_lag[w]);
        check($sformatf("last_w%0d", w), last_a, (w == NW - 1) ? 1 : 0);
        w++;
      end
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    if (w < NW) check("frame_timeout_words", w, NW);
    check("valid_after_frame", valid_a, 0);
    check("busy_after_frame", busy_a, 0);
    m_busy = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_map();
    model_reset();
    zl_tab[0] = '{stall: 0, pair: 0, lag: 0, data: 5, last: 1'b0};
    zl_tab[1] = '{stall: 2, pair: 0, lag: 1, data: 4, last: 1'b0};
    zl_tab[2] = '{stall: 0, pair: 1, lag: 0, data: 0, last: 1'b0};
    zl_tab[3] = '{stall: 1, pair: 1, lag: 1, data: 0, last: 1'b0};
    zl_tab[4] = '{stall: 0, pair: 2, lag: 0, data: 0, last: 1'b0};
    zl_tab[5] = '{stall: 3, pair: 2, lag: 1, data: 0, last: 1'b1};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_data", data_a, 0);
    check("rst_overrun", ovr_a, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Zero-lag count, table driven
    for (int s = 0; s < 5; s++) strobe(3'b011, 1'b0);
    integ();
    for (int t = 0; t < NW; t++) begin
      out_ready = 1'b0;
      repeat (zl_tab[t].stall) @(negedge clk);
      out_ready = 1'b1;
      check($sformatf("zl_valid_%0d", t), valid_a, 1);
      check($sformatf("zl_pair_%0d", t), pair_a, zl_tab[t].pair);
      check($sformatf("zl_lag_%0d", t), lag_a, zl_tab[t].lag);
      check($sformatf("zl_data_sat_%0d", t), data_a, zl_tab[t].data);
      check($sformatf("zl_data_wrap_%0d", t), data_b, zl_tab[t].data);
      check($sformatf("zl_last_%0d", t), last_a, int'(zl_tab[t].last));
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("zl_valid_end", valid_a, 0);
    m_busy = 1'b0;

    // Lag detection
    strobe(3'b000, 1'b0);
    strobe(3'b000, 1'b0);
    strobe(3'b010, 1'b0);
    strobe(3'b001, 1'b0);
    strobe(3'b000, 1'b0);
    integ();
    read_frame(100);
    for (int w = 0; w < NW; w++)
      check($sformatf("lag_word_%0d", w), got_a[w], (w == 1) ? 1 : 0);

    // Saturation vs wrap
    for (int s = 0; s < 20; s++) strobe(3'b011, 1'b0);
    integ();
    read_frame(100);
    check("sat_clamp", got_a[0], 15);
    check("wrap_mod", got_b[0], 4);

    // Backpressure and overrun
    for (int s = 0; s < 3; s++) strobe(3'b111, 1'b0);
    integ();
    begin
      logic [RES-1:0] d0;
      d0 = data_a;
      check("bp_word0", d0, exp_sat[0]);
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        check("bp_hold_data", data_a, d0);
        check("bp_hold_pair", pair_a, 0);
        check("bp_hold_valid", valid_a, 1);
      end
    end
    strobe(3'b011, 1'b0);
    strobe(3'b011, 1'b0);
    integ();
    strobe(3'b101, 1'b0);
    read_frame(70);
    integ();
    read_frame(100);

    // Coincident sample and integration strobes
    strobe(3'b011, 1'b1);
    read_frame(100);
    check("coinc_in_snapshot", got_a[0], 1);
    integ();
    read_frame(100);
    check("coinc_excluded_next", got_a[0], 0);

    // Randomised periods and backpressure
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(30);
      for (int s = 0; s < n; s++) strobe(NI'($urandom_range(7)), 1'b0);
      integ();
      read_frame(60);
    end

    // Reset in the middle of a frame
    for (int s = 0; s < 4; s++) strobe(3'b111, 1'b0);
    integ();
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", valid_a, 0);
    check("mid_rst_last", last_a, 0);
    check("mid_rst_busy", busy_b, 0);
    check("mid_rst_data", data_a, 0);
    check("mid_rst_pair", pair_a, 0);
    check("mid_rst_lag", lag_a, 0);
    check("mid_rst_overrun", ovr_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("post_rst_idle", valid_a, 0);
    end
    integ();
    read_frame(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
